// File: rtl/pcihellocore_led_pkg.sv
// -----------------------------------------------------------------------------
// pcihellocore_led_pkg: register map and STATUS bit positions for the LED PIO. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package pcihellocore_led_pkg;

  typedef enum logic [2:0] {
    REG_DATA   = 3'd0,
    REG_SET    = 3'd1,
    REG_CLR    = 3'd2,
    REG_MASK   = 3'd3,
    REG_PERIOD = 3'd4,
    REG_STATUS = 3'd5
  } reg_addr_e;

  localparam int STATUS_PHASE_BIT  = 0;
  localparam int STATUS_ACTIVE_BIT = 1;

endpackage

`default_nettype wire

// File: rtl/pcihellocore_led_blink_timer.sv
// -----------------------------------------------------------------------------
// pcihellocore_led_blink_timer: down-counter with phase flip-flop toggling every period+1 cycles. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module pcihellocore_led_blink_timer #(
  parameter int PERIOD_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [PERIOD_W-1:0] period,
  output logic                phase
);

  logic [PERIOD_W-1:0] count;

  // A load restarts the blink cycle and wins over a coincident expiry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      phase <= 1'b0;
    end else if (load) begin
      count <= period;
      phase <= 1'b0;
    end else if (period == '0) begin
      count <= '0;
      phase <= 1'b0;
    end else if (count == '0) begin
      count <= period;
      phase <= ~phase;
    end else begin
      count <= count - PERIOD_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pcihellocore_led_pio_blink.sv
// -----------------------------------------------------------------------------
// pcihellocore_led_pio_blink: Avalon-MM LED PIO with set/clear access and per-bit blink mask. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module pcihellocore_led_pio_blink
  import pcihellocore_led_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               PERIOD_W    = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic                wr_en;
  logic [WIDTH-1:0]    wr_bits;
  logic [PERIOD_W-1:0] wr_period;
  logic [WIDTH-1:0]    data;
  logic [WIDTH-1:0]    mask;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] timer_period;
  logic                period_load;
  logic                phase;
  logic                unused_wd;

  assign wr_en       = chipselect & ~write_n;
  assign wr_bits     = writedata[WIDTH-1:0];
  assign wr_period   = writedata[PERIOD_W-1:0];
  assign unused_wd   = ^writedata;
  assign period_load = wr_en && (address == REG_PERIOD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data   <= RESET_VALUE;
      mask   <= '0;
      period <= '0;
    end else if (wr_en) begin
      case (address)
        REG_DATA:   data   <= wr_bits;
        REG_SET:    data   <= data | wr_bits;
        REG_CLR:    data   <= data & ~wr_bits;
        REG_MASK:   mask   <= wr_bits;
        REG_PERIOD: period <= wr_period;
        default:    ;
      endcase
    end
  end

  // The timer sees the incoming value on a PERIOD write so the reload uses it.
  assign timer_period = period_load ? wr_period : period;

  pcihellocore_led_blink_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (period_load),
    .period  (timer_period),
    .phase   (phase)
  );

  assign out_port = data & ~(mask & {WIDTH{phase}});

  always_comb begin
    readdata = '0;
    case (address)
      REG_DATA, REG_SET, REG_CLR: readdata[WIDTH-1:0]    = data;
      REG_MASK:                   readdata[WIDTH-1:0]    = mask;
      REG_PERIOD:                 readdata[PERIOD_W-1:0] = period;
      REG_STATUS: begin
        readdata[STATUS_PHASE_BIT]  = phase;
        readdata[STATUS_ACTIVE_BIT] = (period != '0);
      end
      default:                    readdata = '0;
    endcase
  end

endmodule

`default_nettype wire
